// File: rtl/bram_stream_ctrl.sv
// -----------------------------------------------------------------------------
// bram_stream_ctrl
//   Buffers one AXI-Stream frame into a single-port BRAM, then streams the
//   stored words back out. A start pulse opens a fill; the fill ends on s_tlast
//   or when the BRAM is full. The drain reads the BRAM through a 2-entry output
//   FIFO so egress backpressure never loses a word.
//
// Ports
//   clk, rst_n             : clock (rising edge), async active-low reset
//   start                  : one-cycle pulse, begins a frame (ignored when busy)
//   s_tdata/tvalid/tready/tlast : ingress stream (ready only while filling)
//   m_tdata/tvalid/tready/tlast : egress stream
//   bram_ce/we/addr/wdata  : BRAM port controls; bram_rdata is registered
//                            read data, valid one cycle after the read
//   busy                   : controller is not idle
//   done                   : one-cycle pulse after the last egress beat
//   frame_len              : words stored by the last fill
//   overflow               : last fill reached DEPTH without s_tlast
// -----------------------------------------------------------------------------
module bram_stream_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 12672
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  bram_ce,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   frame_len,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH:0]   r_frame_len;
    logic                  r_overflow;
    logic [ADDR_WIDTH:0]   r_rd_cnt;       // reads issued this drain
    logic [ADDR_WIDTH:0]   r_out_cnt;      // egress beats completed this drain
    logic                  r_rd_inflight;  // a read was issued last cycle
    logic [DATA_WIDTH-1:0] r_fifo_data [0:1];
    logic                  r_fifo_rd_idx;
    logic                  r_fifo_wr_idx;
    logic [1:0]            r_fifo_cnt;
    logic                  r_done;

    logic                  w_wr_beat;
    logic [ADDR_WIDTH:0]   w_len_inc;
    logic                  w_fill_full;
    logic                  w_fill_end;
    logic                  w_fifo_valid;
    logic                  w_fifo_pop;
    logic [ADDR_WIDTH:0]   w_out_inc;
    logic                  w_is_last_beat;
    logic                  w_last_pop;
    logic [1:0]            w_slots_used;
    logic                  w_rd_issue;
    logic                  w_start_frame;

    // The write pointer always equals the number of words stored so far, so
    // it is taken from the length counter instead of a duplicate register.
    // Both the write and read addresses stay below DEPTH because a write only
    // happens while the length is below DEPTH and a read only while the
    // issued count is below the stored length.
    assign w_start_frame  = (r_state == S_IDLE) && start;
    assign w_wr_beat      = (r_state == S_FILL) && s_tvalid;
    assign w_len_inc      = r_frame_len + 1'b1;
    assign w_fill_full    = (w_len_inc == DEPTH_C);
    assign w_fill_end     = w_wr_beat && (s_tlast || w_fill_full);

    assign w_fifo_valid   = (r_fifo_cnt != 2'd0);
    assign w_fifo_pop     = w_fifo_valid && m_tready;
    assign w_out_inc      = r_out_cnt + 1'b1;
    assign w_is_last_beat = (w_out_inc == r_frame_len);
    assign w_last_pop     = (r_state == S_DRAIN) && w_fifo_pop && w_is_last_beat;

    // Slots already claimed once this cycle's pop leaves: counting the pop
    // lets a read issue every cycle under full egress throughput, while the
    // in-flight term keeps the 2-entry FIFO from ever overfilling.
    assign w_slots_used   = r_fifo_cnt - {1'b0, w_fifo_pop} + {1'b0, r_rd_inflight};
    assign w_rd_issue     = (r_state == S_DRAIN) && (r_rd_cnt < r_frame_len)
                            && (w_slots_used < 2'd2);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others; blocking here would create races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        s_tready     = 1'b0;
        bram_ce      = 1'b0;
        bram_we      = 1'b0;
        bram_addr    = '0;
        bram_wdata   = '0;

        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_FILL;
            end
            S_FILL: begin
                s_tready = 1'b1;
                if (w_wr_beat) begin
                    bram_ce    = 1'b1;
                    bram_we    = 1'b1;
                    bram_addr  = r_frame_len[ADDR_WIDTH-1:0];
                    bram_wdata = s_tdata;
                end
                if (w_fill_end) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_rd_issue) begin
                    bram_ce   = 1'b1;
                    bram_addr = r_rd_cnt[ADDR_WIDTH-1:0];
                end
                if (w_last_pop) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: the FIFO storage is reset along with its pointers so m_tdata reads
    // zero during reset; larger memories (the BRAM itself) are never reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_len    <= '0;
            r_overflow     <= 1'b0;
            r_rd_cnt       <= '0;
            r_out_cnt      <= '0;
            r_rd_inflight  <= 1'b0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_rd_idx  <= 1'b0;
            r_fifo_wr_idx  <= 1'b0;
            r_fifo_cnt     <= 2'd0;
            r_done         <= 1'b0;
        end else begin
            r_done        <= w_last_pop;
            r_rd_inflight <= w_rd_issue;
            r_fifo_cnt    <= r_fifo_cnt + {1'b0, r_rd_inflight} - {1'b0, w_fifo_pop};

            if (w_start_frame) begin
                r_frame_len <= '0;
                r_overflow  <= 1'b0;
                r_rd_cnt    <= '0;
                r_out_cnt   <= '0;
            end

            if (w_wr_beat) begin
                r_frame_len <= w_len_inc;
                // A beat that fills the BRAM and also carries s_tlast is a
                // complete frame, not an overflow.
                if (w_fill_full && !s_tlast) r_overflow <= 1'b1;
            end

            if (w_rd_issue) r_rd_cnt <= r_rd_cnt + 1'b1;

            if (w_fifo_pop) begin
                r_out_cnt     <= w_out_inc;
                r_fifo_rd_idx <= ~r_fifo_rd_idx;
            end

            // Registered BRAM data is valid the cycle after the read issued.
            if (r_rd_inflight) begin
                r_fifo_data[r_fifo_wr_idx] <= bram_rdata;
                r_fifo_wr_idx              <= ~r_fifo_wr_idx;
            end
        end
    end

    assign m_tvalid  = w_fifo_valid;
    assign m_tdata   = r_fifo_data[r_fifo_rd_idx];
    assign m_tlast   = w_fifo_valid && w_is_last_beat;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign frame_len = r_frame_len;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_bram_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_ctrl
//   Self-checking bench for bram_stream_ctrl with a small BRAM (DEPTH=8).
//   A driver offers frames and pushes the expected egress words into a
//   scoreboard queue; a monitor on the falling edge pops and compares every
//   egress handshake, checks BRAM write addresses/data, output stability under
//   backpressure and the done pulse.
// -----------------------------------------------------------------------------
module tb_bram_stream_ctrl;

    localparam int AW = 3;
    localparam int DW = 24;
    localparam int DP = 8;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic [DW-1:0] s_tdata  = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast  = 1'b0;
    logic          m_tready = 1'b1;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          bram_ce;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] bram_rdata;
    logic          busy;
    logic          done;
    logic [AW:0]   frame_len;
    logic          overflow;

    bram_stream_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .bram_ce    (bram_ce),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata),
        .busy       (busy),
        .done       (done),
        .frame_len  (frame_len),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Single-port BRAM with registered read data.
    logic [DW-1:0] mem [0:DP-1];
    always @(posedge clk) begin
        if (bram_ce) begin
            if (bram_we) mem[bram_addr] <= bram_wdata;
            else         bram_rdata     <= mem[bram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];

    // 0: m_tready held high, 1: toggles every cycle, 2: random
    int tmode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tmode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------------------------------------------------------- monitor
    int            exp_wr_addr  = 0;
    int            hs_count     = 0;
    int            done_count   = 0;
    int            first_hs_cyc = -1;
    int            last_hs_cyc  = 0;
    int            done_cyc     = 0;
    bit            prev_stall   = 0;
    bit            prev_hs_last = 0;
    logic [DW-1:0] prev_data    = '0;
    logic          prev_last    = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (start && !busy) begin
                exp_wr_addr  = 0;
                first_hs_cyc = -1;
            end
            if (bram_ce && bram_we) begin
                check("wr_addr", 64'(bram_addr), 64'(exp_wr_addr));
                check("wr_data", 64'(bram_wdata), 64'(s_tdata));
                exp_wr_addr++;
            end
            if (prev_stall) begin
                check("hold_valid", 64'(m_tvalid), 64'd1);
                check("hold_data", 64'(m_tdata), 64'(prev_data));
                check("hold_last", 64'(m_tlast), 64'(prev_last));
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
                check("done_after_last_beat", 64'(prev_hs_last), 64'd1);
            end
            prev_hs_last = m_tvalid && m_tready && m_tlast;
            if (m_tvalid && m_tready) begin
                check("egress_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("m_tdata", 64'(m_tdata), 64'(e.data));
                    check("m_tlast", 64'(m_tlast), 64'(e.last));
                end
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                hs_count++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end else begin
            prev_stall   = 0;
            prev_hs_last = 0;
        end
    end

    // ----------------------------------------------------------------- driver
    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 64'({s_tready, m_tvalid, m_tlast, bram_ce, bram_we, busy, done, overflow}), 64'd0);
        check({tag, "_data"}, 64'({m_tdata, bram_wdata}), 64'd0);
        check({tag, "_addr_len"}, 64'({bram_addr, frame_len}), 64'd0);
    endtask

    // Offers n words; the reference rule is that the first min(n, DP) words
    // are stored and come back in order, with m_tlast on the final stored one.
    task automatic send_frame(input int n, input bit with_last, input bit seq_data,
                              input bit gaps, input bit start_in_fill,
                              output int acc, output int last_acc_cyc);
        logic [DW-1:0] w [$];
        beat_t         b;
        bit            ok;
        acc          = (n < DP) ? n : DP;
        last_acc_cyc = 0;
        for (int i = 0; i < n; i++) w.push_back(seq_data ? DW'(i + 1) : DW'($urandom));
        for (int i = 0; i < acc; i++) begin
            b.data = w[i];
            b.last = (i == acc - 1);
            exp_q.push_back(b);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            s_tdata  = w[i];
            s_tlast  = with_last && (i == n - 1);
            s_tvalid = 1'b1;
            if (start_in_fill && i == 1) start = 1'b1;
            if (i < acc) begin
                ok = 0;
                for (int k = 0; k < 50 && !ok; k++) begin
                    @(negedge clk);
                    if (s_tready) ok = 1;
                    else begin @(posedge clk); #1; end
                end
                check("ingress_accept", 64'(ok), 64'd1);
                last_acc_cyc = cyc;
            end else begin
                @(negedge clk);
                check("s_tready_after_full", 64'(s_tready), 64'd0);
            end
            @(posedge clk); #1;
            start    = 1'b0;
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
    endtask

    task automatic finish_frame(input int acc, input bit exp_ovf, input int mode,
                                input int last_acc_cyc, input int d0, input bit start_in_drain);
        if (start_in_drain) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            check("busy_in_drain", 64'(busy), 64'd1);
            check("len_in_drain", 64'(frame_len), 64'(acc));
        end
        for (int k = 0; k < 300; k++) begin
            if (done_count != d0) break;
            @(posedge clk);
        end
        #1;
        check("done_count", 64'(done_count - d0), 64'd1);
        check("frame_len", 64'(frame_len), 64'(acc));
        check("overflow", 64'(overflow), 64'(exp_ovf));
        check("idle_after_done", 64'(busy), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        if (mode == 0) begin
            check("first_beat_latency", 64'(first_hs_cyc - last_acc_cyc), 64'd3);
            check("beat_span", 64'(last_hs_cyc - first_hs_cyc), 64'(acc - 1));
            check("done_delay", 64'(done_cyc - last_hs_cyc), 64'd1);
        end
        repeat (3) @(negedge clk);
        check("len_held", 64'({overflow, frame_len}), 64'({exp_ovf, AW'(0) + (AW+1)'(acc)}));
    endtask

    task automatic run_frame(input int n, input bit with_last, input bit seq_data, input int mode,
                             input bit gaps, input bit start_in_fill, input bit start_in_drain);
        int acc;
        int lac;
        int d0;
        tmode = mode;
        d0    = done_count;
        send_frame(n, with_last, seq_data, gaps, start_in_fill, acc, lac);
        finish_frame(acc, !(with_last && n <= DP), mode, lac, d0, start_in_drain);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc;
        int lac;
        int d0;
        int h0;
        int n;
        bit wl;

        #2;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame: 1..4, tlast on the 4th, full egress throughput.
        run_frame(4, 1, 1, 0, 0, 0, 0);
        // Egress backpressure: m_tready toggles every cycle.
        run_frame(8, 1, 0, 1, 0, 0, 0);
        // Overflow: 10 words without tlast, only DEPTH stored.
        run_frame(10, 0, 0, 0, 0, 0, 0);
        // tlast exactly at DEPTH: complete frame, no overflow.
        run_frame(8, 1, 0, 0, 0, 0, 0);
        // Single-word frame.
        run_frame(1, 1, 0, 0, 0, 0, 0);
        // Start pulses while filling and while draining are ignored.
        run_frame(5, 1, 0, 0, 0, 1, 1);

        // Reset mid-drain after 3 of 6 beats.
        tmode = 0;
        d0    = done_count;
        h0    = hs_count;
        send_frame(6, 1, 0, 0, 0, acc, lac);
        for (int k = 0; k < 100; k++) begin
            if (hs_count >= h0 + 3) break;
            @(posedge clk);
        end
        check("beats_before_reset", 64'(hs_count - h0), 64'd3);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("mid_drain_reset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        check("no_done_on_reset", 64'(done_count - d0), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("after_reset_idle");
        run_frame(3, 1, 1, 0, 0, 0, 0);

        // Randomized frames.
        for (int f = 0; f < 10; f++) begin
            n  = $urandom_range(1, DP);
            wl = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                n  = $urandom_range(DP, DP + 3);
                wl = 1'($urandom_range(0, 1));
            end
            run_frame(n, wl, 0, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_stream_ctrl.md
BRAM_STREAM_CTRL -- requirements
Module: bram_stream_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, the BRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 24, the pixel/word width.
REQ-003 SHALL have parameter DEPTH, default 12672, the BRAM capacity in words.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: a single-cycle pulse that begins a frame.
REQ-007 SHALL have port s_tdata, input, DATA_WIDTH: the ingress AXI-Stream data.
REQ-008 SHALL have ports s_tvalid (input, 1), s_tready (output, 1) and s_tlast (input, 1): the ingress handshake and end-of-frame marker.
REQ-009 SHALL have port m_tdata, output, DATA_WIDTH: the egress AXI-Stream data.
REQ-010 SHALL have ports m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1): the egress handshake and end-of-frame marker.
REQ-011 SHALL have ports bram_ce (output, 1) and bram_we (output, 1): the BRAM port enable and write enable.
REQ-012 SHALL have port bram_addr, output, ADDR_WIDTH: the BRAM address.
REQ-013 SHALL have ports bram_wdata (output, DATA_WIDTH) and bram_rdata (input, DATA_WIDTH): the BRAM write data and registered read data.
REQ-014 SHALL have ports busy (output, 1) and done (output, 1): busy = state not IDLE; done = single-cycle completion pulse.
REQ-015 SHALL have port frame_len, output, ADDR_WIDTH+1: the number of words stored in the last fill.
REQ-016 SHALL have port overflow, output, 1: a sticky flag, set when the fill hit DEPTH without s_tlast.

Function
REQ-017 SHALL implement the states IDLE, FILL and DRAIN.
REQ-018 IDLE -> FILL on start=1; frame_len, overflow and wr_ptr are cleared on this transition.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 SHALL assert s_tready only in FILL.
REQ-021 FILL write: on an accepted beat (s_tvalid & s_tready), drive combinationally in the same cycle bram_ce=1, bram_we=1, bram_addr=wr_ptr, bram_wdata=s_tdata.
REQ-022 After each write, wr_ptr and frame_len SHALL increment by 1.
REQ-023 FILL -> DRAIN after the accepted beat that has s_tlast=1, or after the accepted beat that makes frame_len == DEPTH; in the latter case without s_tlast, overflow=1.
REQ-024 When s_tlast and frame_len==DEPTH coincide, overflow SHALL stay 0.
REQ-025 DRAIN read: issue a read (bram_ce=1, bram_we=0, bram_addr=rd_ptr, rd_ptr++) in any cycle where issued < frame_len and (FIFO occupancy + reads in flight) < 2.
REQ-026 bram_rdata is valid exactly 1 cycle after the read is issued and SHALL be pushed into a 2-entry output FIFO that cannot overflow.
REQ-027 m_tvalid SHALL equal FIFO not empty, with m_tdata = FIFO head.
REQ-028 A beat SHALL pop on m_tvalid & m_tready; m_tvalid and m_tdata stay stable while m_tready=0.
REQ-029 m_tlast SHALL be 1 only on beat number frame_len (counted from 1).
REQ-030 Latency: the first m_tvalid occurs 2 cycles after DRAIN is entered.
REQ-031 Throughput: with m_tready held at 1, one beat per cycle with no bubbles.
REQ-032 DRAIN -> IDLE on the cycle after the last beat handshake completes; done=1 for exactly that 1 cycle.
REQ-033 frame_len and overflow SHALL hold their values until the next start.
REQ-034 bram_ce SHALL be 0 in every cycle with no read or write; bram_we=1 only on FILL writes.
REQ-035 Read and write SHALL never occur in the same cycle.
REQ-036 Pointer arithmetic SHALL be unsigned; pointers never exceed DEPTH-1, with no wrap within a frame.

Reset
REQ-037 rst_n=0 SHALL, immediately and asynchronously, force state=IDLE and clear all pointers, counters and the FIFO.
REQ-038 During reset, all outputs SHALL be 0: s_tready, m_tvalid, m_tlast, m_tdata, bram_ce, bram_we, bram_addr, bram_wdata, busy, done, frame_len, overflow.
REQ-039 A reset mid-FILL or mid-DRAIN SHALL abandon the frame with no done pulse; BRAM contents are not cleared.

Verification
REQ-040 Bench SHALL run a basic frame: start, then 4 beats 0x000001..0x000004 with tlast on the 4th, m_tready=1 -> 4 BRAM writes at addr 0..3, frame_len=4, m_tdata 1,2,3,4 on consecutive cycles, m_tlast on the 4th, done 1 cycle later, overflow=0.
REQ-041 Bench SHALL run egress backpressure: 8-beat frame, m_tready toggled every cycle -> all 8 words in order with none dropped or duplicated, m_tdata stable while m_tready=0.
REQ-042 Bench SHALL run overflow: DEPTH=8, 10 beats offered without tlast -> exactly 8 accepted, s_tready=0 afterward, overflow=1, frame_len=8, 8 beats drained with m_tlast on the 8th.
REQ-043 Bench SHALL run a single-word frame: 1 beat with tlast -> frame_len=1, one egress beat with m_tlast=1, then done.
REQ-044 Bench SHALL run start while busy: a start pulse in FILL and in DRAIN -> no state or counter change.
REQ-045 Bench SHALL run reset mid-DRAIN: rst_n=0 after 3 of 6 beats -> all outputs 0 immediately, no done pulse; after a new start, the new frame is processed correctly.
